l2_arbiter: RTL and testbench

Two-port arbiter that shares the single L2 cache request port between the L1 instruction cache and the L1 data cache. It sits between the two L1 miss ports and the upstream side of `l2_cache`. It grants one 128-bit line transaction at a time and registers the winning request. It forwards the L2 response only to the granted requester, and alternates priority round-robin when both L1s miss at once.

---
 rtl/l2_arbiter.sv | 133 +++++++++++++
 tb/tb_l2_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Shares the single L2 request port between the L1 I-cache and D-cache.
// One line transaction at a time. Priority alternates round-robin when both L1s miss together.
module l2_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_mem_read,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  output logic                  i_mem_resp,
  output logic [LINE_WIDTH-1:0] i_mem_rdata,

  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_wdata,
  output logic                  d_mem_resp,
  output logic [LINE_WIDTH-1:0] d_mem_rdata,

  output logic                  l2_mem_read,
  output logic                  l2_mem_write,
  output logic [ADDR_WIDTH-1:0] l2_mem_address,
  output logic [LINE_WIDTH-1:0] l2_mem_wdata,
  input  logic                  l2_mem_resp,
  input  logic [LINE_WIDTH-1:0] l2_mem_rdata
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;
  typedef enum logic [0:0] {ReqI, ReqD} req_e;

  state_e                state_q, state_d;
  req_e                  owner_q, owner_d;
  req_e                  last_q, last_d;
  req_e                  done_id_q, done_id_d;
  req_e                  winner;
  logic                  op_rd_q, op_rd_d;
  logic                  op_wr_q, op_wr_d;
  logic                  just_done_q, just_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  i_elig, d_elig;

  // The requester that just finished is ignored for one cycle, in case it drops its request late.
  assign i_elig = i_mem_read & ~(just_done_q & (done_id_q == ReqI));
  assign d_elig = (d_mem_read | d_mem_write) & ~(just_done_q & (done_id_q == ReqD));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    done_id_d   = done_id_q;
    op_rd_d     = op_rd_q;
    op_wr_d     = op_wr_q;
    just_done_d = just_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    winner      = ReqI;
    i_mem_resp  = 1'b0;
    d_mem_resp  = 1'b0;

    unique case (state_q)
      StIdle: begin
        just_done_d = 1'b0;
        if (i_elig || d_elig) begin
          if (i_elig && d_elig) begin
            winner = (last_q == ReqI) ? ReqD : ReqI;
          end else begin
            winner = d_elig ? ReqD : ReqI;
          end
          state_d = StBusy;
          owner_d = winner;
          last_d  = winner;
          wdata_d = d_mem_wdata;
          if (winner == ReqI) begin
            addr_d  = i_mem_address;
            op_rd_d = 1'b1;
            op_wr_d = 1'b0;
          end else begin
            // A writeback takes precedence if D raises read and write together.
            addr_d  = d_mem_address;
            op_rd_d = ~d_mem_write;
            op_wr_d = d_mem_write;
          end
        end
      end
      StBusy: begin
        if (l2_mem_resp) begin
          i_mem_resp  = (owner_q == ReqI);
          d_mem_resp  = (owner_q == ReqD);
          state_d     = StIdle;
          just_done_d = 1'b1;
          done_id_d   = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= ReqI;
      last_q      <= ReqI;
      done_id_q   <= ReqI;
      op_rd_q     <= 1'b0;
      op_wr_q     <= 1'b0;
      just_done_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      done_id_q   <= done_id_d;
      op_rd_q     <= op_rd_d;
      op_wr_q     <= op_wr_d;
      just_done_q <= just_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign l2_mem_read    = (state_q == StBusy) & op_rd_q;
  assign l2_mem_write   = (state_q == StBusy) & op_wr_q;
  assign l2_mem_address = addr_q;
  assign l2_mem_wdata   = wdata_q;

  assign i_mem_rdata = l2_mem_rdata;
  assign d_mem_rdata = l2_mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_l2_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_address;
  logic          i_mem_resp;
  logic [LW-1:0] i_mem_rdata;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_address;
  logic [LW-1:0] d_mem_wdata;
  logic          d_mem_resp;
  logic [LW-1:0] d_mem_rdata;
  logic          l2_mem_read;
  logic          l2_mem_write;
  logic [AW-1:0] l2_mem_address;
  logic [LW-1:0] l2_mem_wdata;
  logic          l2_mem_resp;
  logic [LW-1:0] l2_mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_mem_read     (i_mem_read),
    .i_mem_address  (i_mem_address),
    .i_mem_resp     (i_mem_resp),
    .i_mem_rdata    (i_mem_rdata),
    .d_mem_read     (d_mem_read),
    .d_mem_write    (d_mem_write),
    .d_mem_address  (d_mem_address),
    .d_mem_wdata    (d_mem_wdata),
    .d_mem_resp     (d_mem_resp),
    .d_mem_rdata    (d_mem_rdata),
    .l2_mem_read    (l2_mem_read),
    .l2_mem_write   (l2_mem_write),
    .l2_mem_address (l2_mem_address),
    .l2_mem_wdata   (l2_mem_wdata),
    .l2_mem_resp    (l2_mem_resp),
    .l2_mem_rdata   (l2_mem_rdata)
  );

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle_inputs();
    i_mem_read    = 1'b0;
    i_mem_address = '0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_mem_address = '0;
    d_mem_wdata   = '0;
    l2_mem_resp   = 1'b0;
    l2_mem_rdata  = '0;
  endtask

  // Returns on the falling edge just after the reset edge.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (l2_mem_read !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", l2_mem_read); end
    n_cmp++; if (l2_mem_write !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %b want 0", l2_mem_write); end
    n_cmp++; if (l2_mem_address !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", l2_mem_address); end
    n_cmp++; if (l2_mem_wdata !== '0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", l2_mem_wdata); end
    n_cmp++; if (i_mem_resp !== 1'b0 || d_mem_resp !== 1'b0) begin
      n_err++; $display("FAIL reset_resp: got i=%b d=%b want 0 0", i_mem_resp, d_mem_resp);
    end
  endtask

  task automatic test_i_read();
    logic [LW-1:0] line;
    line = {16{8'hA5}};
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 16'h1230;
    #1;
    n_cmp++; if (l2_mem_read !== 1'b0) begin n_err++; $display("FAIL iread_nocomb: got %b want 0", l2_mem_read); end
    @(negedge clk); #1;
    n_cmp++; if (l2_mem_read !== 1'b1 || l2_mem_write !== 1'b0) begin
      n_err++; $display("FAIL iread_req: got rd=%b wr=%b want 1 0", l2_mem_read, l2_mem_write);
    end
    n_cmp++; if (l2_mem_address !== 16'h1230) begin n_err++; $display("FAIL iread_addr: got %h want 1230", l2_mem_address); end
    @(negedge clk);
    l2_mem_resp = 1'b1; l2_mem_rdata = line;
    #1;
    n_cmp++; if (i_mem_resp !== 1'b1 || d_mem_resp !== 1'b0) begin
      n_err++; $display("FAIL iread_resp: got i=%b d=%b want 1 0", i_mem_resp, d_mem_resp);
    end
    n_cmp++; if (i_mem_rdata !== line) begin n_err++; $display("FAIL iread_rdata: got %h want %h", i_mem_rdata, line); end
    @(negedge clk);
    l2_mem_resp = 1'b0; i_mem_read = 1'b0;
    #1;
    n_cmp++; if (l2_mem_read !== 1'b0) begin n_err++; $display("FAIL iread_done: got %b want 0", l2_mem_read); end
  endtask

  task automatic test_tie();
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 16'h0100;
    d_mem_read = 1'b1; d_mem_address = 16'h0200;
    @(negedge clk); #1;
    n_cmp++; if (l2_mem_read !== 1'b1 || l2_mem_address !== 16'h0200) begin
      n_err++; $display("FAIL tie_first: got rd=%b addr=%h want 1 0200", l2_mem_read, l2_mem_address);
    end
    @(negedge clk); l2_mem_resp = 1'b1; #1;
    n_cmp++; if (d_mem_resp !== 1'b1 || i_mem_resp !== 1'b0) begin
      n_err++; $display("FAIL tie_dresp: got d=%b i=%b want 1 0", d_mem_resp, i_mem_resp);
    end
    @(negedge clk); l2_mem_resp = 1'b0; d_mem_read = 1'b0; #1;
    n_cmp++; if (l2_mem_read !== 1'b0 || l2_mem_write !== 1'b0) begin
      n_err++; $display("FAIL tie_gap1: got rd=%b wr=%b want 0 0", l2_mem_read, l2_mem_write);
    end
    @(negedge clk); #1;
    n_cmp++; if (l2_mem_read !== 1'b1 || l2_mem_address !== 16'h0100) begin
      n_err++; $display("FAIL tie_second: got rd=%b addr=%h want 1 0100", l2_mem_read, l2_mem_address);
    end
    @(negedge clk); l2_mem_resp = 1'b1; #1;
    n_cmp++; if (i_mem_resp !== 1'b1 || d_mem_resp !== 1'b0) begin
      n_err++; $display("FAIL tie_iresp: got i=%b d=%b want 1 0", i_mem_resp, d_mem_resp);
    end
    @(negedge clk); l2_mem_resp = 1'b0; i_mem_read = 1'b0; #1;
    n_cmp++; if (l2_mem_read !== 1'b0) begin n_err++; $display("FAIL tie_gap2: got %b want 0", l2_mem_read); end
  endtask

  task automatic test_write_priority();
    logic [LW-1:0] line;
    line = {8{16'hDEAD}};
    do_reset();
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 16'h0400; d_mem_wdata = line;
    @(negedge clk);
    d_mem_wdata = {8{16'hBEEF}};
    #1;
    n_cmp++; if (l2_mem_write !== 1'b1 || l2_mem_read !== 1'b0) begin
      n_err++; $display("FAIL wpri_op: got wr=%b rd=%b want 1 0", l2_mem_write, l2_mem_read);
    end
    n_cmp++; if (l2_mem_address !== 16'h0400) begin n_err++; $display("FAIL wpri_addr: got %h want 0400", l2_mem_address); end
    @(negedge clk); #1;
    n_cmp++; if (l2_mem_wdata !== line) begin n_err++; $display("FAIL wpri_wdata: got %h want %h", l2_mem_wdata, line); end
    @(negedge clk); l2_mem_resp = 1'b1; #1;
    n_cmp++; if (d_mem_resp !== 1'b1) begin n_err++; $display("FAIL wpri_resp: got %b want 1", d_mem_resp); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_late_drop();
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 16'h0040;
    @(negedge clk);
    @(negedge clk); l2_mem_resp = 1'b1; #1;
    n_cmp++; if (i_mem_resp !== 1'b1) begin n_err++; $display("FAIL late_resp: got %b want 1", i_mem_resp); end
    @(negedge clk); l2_mem_resp = 1'b0; #1;
    n_cmp++; if (l2_mem_read !== 1'b0) begin n_err++; $display("FAIL late_gap: got %b want 0", l2_mem_read); end
    @(negedge clk); i_mem_read = 1'b0; #1;
    n_cmp++; if (l2_mem_read !== 1'b0 || l2_mem_write !== 1'b0) begin
      n_err++; $display("FAIL late_regrant: got rd=%b wr=%b want 0 0", l2_mem_read, l2_mem_write);
    end
    @(negedge clk); #1;
    n_cmp++; if (l2_mem_read !== 1'b0) begin n_err++; $display("FAIL late_idle: got %b want 0", l2_mem_read); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_mem_write = 1'b1; d_mem_address = 16'h0800; d_mem_wdata = rand_line();
    @(negedge clk); #1;
    n_cmp++; if (l2_mem_write !== 1'b1) begin n_err++; $display("FAIL rmid_wr: got %b want 1", l2_mem_write); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; d_mem_write = 1'b0;
    #1;
    n_cmp++; if (l2_mem_write !== 1'b0 || l2_mem_read !== 1'b0) begin
      n_err++; $display("FAIL rmid_drop: got wr=%b rd=%b want 0 0", l2_mem_write, l2_mem_read);
    end
    @(negedge clk); l2_mem_resp = 1'b1; #1;
    n_cmp++; if (d_mem_resp !== 1'b0 || i_mem_resp !== 1'b0) begin
      n_err++; $display("FAIL rmid_lateresp: got d=%b i=%b want 0 0", d_mem_resp, i_mem_resp);
    end
    @(negedge clk); l2_mem_resp = 1'b0; i_mem_read = 1'b1; i_mem_address = 16'h0123;
    @(negedge clk); #1;
    n_cmp++; if (l2_mem_read !== 1'b1 || l2_mem_address !== 16'h0123) begin
      n_err++; $display("FAIL rmid_newgrant: got rd=%b addr=%h want 1 0123", l2_mem_read, l2_mem_address);
    end
    @(negedge clk); l2_mem_resp = 1'b1; #1;
    n_cmp++; if (i_mem_resp !== 1'b1) begin n_err++; $display("FAIL rmid_iresp: got %b want 1", i_mem_resp); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_stray_resp();
    do_reset();
    @(negedge clk); l2_mem_resp = 1'b1; #1;
    n_cmp++; if (i_mem_resp !== 1'b0 || d_mem_resp !== 1'b0) begin
      n_err++; $display("FAIL stray_resp: got i=%b d=%b want 0 0", i_mem_resp, d_mem_resp);
    end
    @(negedge clk); l2_mem_resp = 1'b0; #1;
    n_cmp++; if (l2_mem_read !== 1'b0 || l2_mem_write !== 1'b0) begin
      n_err++; $display("FAIL stray_state: got rd=%b wr=%b want 0 0", l2_mem_read, l2_mem_write);
    end
    // A tie right after the stray pulse must still go to D first.
    i_mem_read = 1'b1; i_mem_address = 16'h0aa0;
    d_mem_read = 1'b1; d_mem_address = 16'h0bb0;
    @(negedge clk); #1;
    n_cmp++; if (l2_mem_address !== 16'h0bb0 || l2_mem_read !== 1'b1) begin
      n_err++; $display("FAIL stray_tie: got rd=%b addr=%h want 1 0bb0", l2_mem_read, l2_mem_address);
    end
    @(negedge clk); idle_inputs();
  endtask

  // Randomized L1/L2 traffic. The model only knows the transaction in flight, who was served
  // last, and who must be ignored right after finishing.
  task automatic test_random(input int cycles);
    bit            m_busy, m_owner_d, m_last_d, m_mask, m_mask_d;
    bit            m_rd, m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, line;
    int            lat, served;
    bit            i_saw, d_saw, i_hold, d_hold, ei, ed, win_d, exp_i, exp_d;
    int            i_gap, d_gap, op;
    do_reset();
    m_busy = 0; m_owner_d = 0; m_last_d = 0; m_mask = 0; m_mask_d = 0;
    m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0; line = '0;
    lat = 0; served = 0; i_saw = 0; d_saw = 0; i_hold = 0; d_hold = 0;
    i_gap = 0; d_gap = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (i_saw) begin
        i_saw = 0;
        if ($urandom_range(0, 1) == 1) i_hold = 1;
        else begin i_mem_read = 1'b0; i_gap = $urandom_range(0, 3); end
      end else if (i_hold) begin
        i_hold = 0; i_mem_read = 1'b0; i_gap = $urandom_range(0, 3);
      end else if (!i_mem_read) begin
        if (i_gap == 0) begin i_mem_read = 1'b1; i_mem_address = 16'($urandom()); end
        else i_gap--;
      end
      if (d_saw) begin
        d_saw = 0;
        if ($urandom_range(0, 1) == 1) d_hold = 1;
        else begin d_mem_read = 1'b0; d_mem_write = 1'b0; d_gap = $urandom_range(0, 3); end
      end else if (d_hold) begin
        d_hold = 0; d_mem_read = 1'b0; d_mem_write = 1'b0; d_gap = $urandom_range(0, 3);
      end else if (!(d_mem_read || d_mem_write)) begin
        if (d_gap == 0) begin
          op = $urandom_range(0, 2);
          d_mem_read  = (op != 1);
          d_mem_write = (op != 0);
          d_mem_address = 16'($urandom());
        end else d_gap--;
      end
      d_mem_wdata = rand_line();
      l2_mem_resp = 1'b0;
      if (m_busy) begin
        if (lat == 0) begin l2_mem_resp = 1'b1; line = rand_line(); l2_mem_rdata = line; end
        else lat--;
      end else if ($urandom_range(0, 7) == 0) begin
        l2_mem_resp = 1'b1; line = rand_line(); l2_mem_rdata = line;
      end
      #1;
      exp_i = m_busy && l2_mem_resp && !m_owner_d;
      exp_d = m_busy && l2_mem_resp && m_owner_d;
      n_cmp++; if (l2_mem_read !== (m_busy && m_rd) || l2_mem_write !== (m_busy && m_wr)) begin
        n_err++;
        $display("FAIL rnd_op c=%0d: got rd=%b wr=%b want %b %b", c, l2_mem_read, l2_mem_write,
                 m_busy && m_rd, m_busy && m_wr);
      end
      if (m_busy) begin
        n_cmp++; if (l2_mem_address !== m_addr) begin
          n_err++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, l2_mem_address, m_addr);
        end
        n_cmp++; if (l2_mem_wdata !== m_wdata) begin
          n_err++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, l2_mem_wdata, m_wdata);
        end
      end
      n_cmp++; if (i_mem_resp !== exp_i || d_mem_resp !== exp_d) begin
        n_err++;
        $display("FAIL rnd_resp c=%0d: got i=%b d=%b want %b %b", c, i_mem_resp, d_mem_resp,
                 exp_i, exp_d);
      end
      if (l2_mem_resp) begin
        n_cmp++; if (i_mem_rdata !== line || d_mem_rdata !== line) begin
          n_err++; $display("FAIL rnd_rdata c=%0d: got %h/%h want %h", c, i_mem_rdata, d_mem_rdata, line);
        end
      end
      i_saw = exp_i;
      d_saw = exp_d;
      // Advance the model across the coming rising edge.
      if (m_busy) begin
        if (l2_mem_resp) begin m_busy = 0; m_mask = 1; m_mask_d = m_owner_d; served++; end
      end else begin
        ei = i_mem_read && !(m_mask && !m_mask_d);
        ed = (d_mem_read || d_mem_write) && !(m_mask && m_mask_d);
        m_mask = 0;
        if (ei || ed) begin
          win_d = (ei && ed) ? !m_last_d : ed;
          m_busy = 1; m_owner_d = win_d; m_last_d = win_d; m_wdata = d_mem_wdata;
          lat = $urandom_range(0, 3);
          if (win_d) begin m_addr = d_mem_address; m_wr = d_mem_write; m_rd = !d_mem_write; end
          else begin m_addr = i_mem_address; m_rd = 1; m_wr = 0; end
        end
      end
    end
    n_cmp++; if (served < cycles / 10) begin
      n_err++; $display("FAIL rnd_progress: got %0d served want >= %0d", served, cycles / 10);
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_i_read();
    test_tie();
    test_write_priority();
    test_late_drop();
    test_reset_mid();
    test_stray_resp();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
